// File: rtl/if_id_pkg.sv
// IF/ID pipeline buffer: shared constants and the buffered entry type.
// Optional build macro used by the buffer: IFID_STALL_CNT_EN.
package if_id_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc;
    } entry_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// IF/ID buffer bus: fetch-side push handshake, decode-side pop handshake and flush.
// The buffer itself takes the slave view; the fetch/decode environment takes master.
interface if_id_buffer_if #(
    parameter int unsigned DATA_W = 32
) ();

    logic [DATA_W-1:0] InInstruction;
    logic [DATA_W-1:0] InPC;
    logic              InValid;
    logic              InReady;
    logic              Flush;
    logic [DATA_W-1:0] OutInstruction;
    logic [DATA_W-1:0] OutPC;
    logic [DATA_W-1:0] OutPCPlus4;
    logic              OutValid;
    logic              OutReady;

    modport slave (
        input  InInstruction, InPC, InValid, Flush, OutReady,
        output InReady, OutInstruction, OutPC, OutPCPlus4, OutValid
    );

    modport master (
        output InInstruction, InPC, InValid, Flush, OutReady,
        input  InReady, OutInstruction, OutPC, OutPCPlus4, OutValid
    );

endinterface

// File: rtl/if_id_buffer.sv
// IF/ID buffer: 2-entry in-order FIFO of {instruction, pc} between fetch and decode.
// InReady/OutValid come from the registered count only; Flush empties the buffer
// and drops that cycle's input. Defining IFID_STALL_CNT_EN adds the StallCount
// output, counting cycles where decode holds a valid head.
module if_id_buffer
    import if_id_pkg::*;
#(
    parameter int unsigned       DATA_W   = XLEN,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP)
) (
    input  logic        Clk,
    input  logic        Reset,
`ifdef IFID_STALL_CNT_EN
    output logic [31:0] StallCount,
`endif
    if_id_buffer_if.slave bus
);

    entry_t            mem [DEPTH];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              push;
    logic              pop;
    entry_t            head;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_pc;

    assign bus.InReady  = (count < 2'(DEPTH));
    assign bus.OutValid = (count != '0);
    assign push         = bus.InValid && bus.InReady;
    assign pop          = bus.OutValid && bus.OutReady;
    assign head         = mem[rd_ptr];

    // Head presentation: NOP and PC 0 when empty, otherwise the oldest entry.
    always_comb begin
        out_instr = NOP_WORD;
        out_pc    = '0;
        if (bus.OutValid) begin
            out_instr = DATA_W'(head.instruction);
            out_pc    = DATA_W'(head.pc);
        end
    end

    assign bus.OutInstruction = out_instr;
    assign bus.OutPC          = out_pc;
    assign bus.OutPCPlus4     = out_pc + DATA_W'(4);

    // Storage, pointers and occupancy; flush wins over any push/pop that cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else if (bus.Flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{instruction: XLEN'(bus.InInstruction), pc: XLEN'(bus.InPC)};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef IFID_STALL_CNT_EN
    // Decode back-pressure counter; survives Flush, cleared only by Reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            StallCount <= '0;
        end else if (bus.OutValid && !bus.OutReady) begin
            StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: a queue of accepted {instruction, pc}
// pairs is the reference; a negedge monitor checks the presented head and pops
// the queue whenever decode consumes. Covers IFID_STALL_CNT_EN when defined.
module tb_if_id_buffer;

    localparam logic [31:0] NOP_EXP = 32'h0000_0000;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    logic Clk;
    logic Reset;
`ifdef IFID_STALL_CNT_EN
    logic [31:0] StallCount;
    int unsigned exp_stall = 0;
`endif

    if_id_buffer_if #(.DATA_W(32)) bus ();

    if_id_buffer #(
        .DATA_W   (32),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
`ifdef IFID_STALL_CNT_EN
        .StallCount (StallCount),
`endif
        .bus        (bus)
    );

    ent_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    bit          mon_en   = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus; the model decides acceptance from its own occupancy.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        logic take;
        bus.InValid       = v;
        bus.InPC          = pc;
        bus.InInstruction = ins;
        bus.OutReady      = ordy;
        bus.Flush         = fl;
        take = v && !fl && (exp_q.size() < 2);
        @(posedge Clk);
        #1;
        if (fl) exp_q.delete();
        else if (take) exp_q.push_back('{ins: ins, pc: pc});
    endtask

    // Monitor: compare presented head against the scoreboard, retire on consume.
    always @(negedge Clk) begin
        if (mon_en && Reset) begin
            check("out_valid", {31'b0, bus.OutValid}, {31'b0, exp_q.size() > 0});
            check("in_ready", {31'b0, bus.InReady}, {31'b0, exp_q.size() < 2});
            if (exp_q.size() == 0) begin
                check("empty_instr", bus.OutInstruction, NOP_EXP);
                check("empty_pc", bus.OutPC, 32'h0);
                check("empty_pc4", bus.OutPCPlus4, 32'h4);
            end else begin
                check("head_instr", bus.OutInstruction, exp_q[0].ins);
                check("head_pc", bus.OutPC, exp_q[0].pc);
                check("head_pc4", bus.OutPCPlus4, exp_q[0].pc + 32'd4);
            end
`ifdef IFID_STALL_CNT_EN
            check("stall_cnt", StallCount, exp_stall);
            if (exp_q.size() > 0 && !bus.OutReady) exp_stall++;
`endif
            if (exp_q.size() > 0 && bus.OutReady) void'(exp_q.pop_front());
        end
    end

    initial begin
        logic [31:0] pc;
        Reset             = 1'b0;
        bus.InValid       = 1'b0;
        bus.InPC          = '0;
        bus.InInstruction = '0;
        bus.OutReady      = 1'b0;
        bus.Flush         = 1'b0;

        // Reset held for two cycles
        repeat (2) @(posedge Clk);
        #1;
        check("rst_out_valid", {31'b0, bus.OutValid}, 32'h0);
        check("rst_in_ready", {31'b0, bus.InReady}, 32'h1);
        check("rst_instr", bus.OutInstruction, NOP_EXP);
        check("rst_pc", bus.OutPC, 32'h0);
        check("rst_pc4", bus.OutPCPlus4, 32'h4);
`ifdef IFID_STALL_CNT_EN
        check("rst_stall", StallCount, 32'h0);
`endif
        Reset  = 1'b1;
        mon_en = 1;

        // Streaming: PC 0, 4, 8 back to back with decode always ready
        step(1'b1, 32'h0, 32'hA000_0000, 1'b1, 1'b0);
        check("stream0_pc", bus.OutPC, 32'h0);
        check("stream0_pc4", bus.OutPCPlus4, 32'h4);
        step(1'b1, 32'h4, 32'hA000_0004, 1'b1, 1'b0);
        check("stream1_pc", bus.OutPC, 32'h4);
        check("stream1_pc4", bus.OutPCPlus4, 32'h8);
        step(1'b1, 32'h8, 32'hA000_0008, 1'b1, 1'b0);
        check("stream2_pc", bus.OutPC, 32'h8);
        check("stream2_pc4", bus.OutPCPlus4, 32'hC);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Stall: third push refused, head held, then drained in order
        step(1'b1, 32'h10, 32'hB000_0010, 1'b0, 1'b0);
        step(1'b1, 32'h14, 32'hB000_0014, 1'b0, 1'b0);
        check("stall_full_ready", {31'b0, bus.InReady}, 32'h0);
        step(1'b1, 32'h18, 32'hB000_0018, 1'b0, 1'b0);
        check("stall_head_pc", bus.OutPC, 32'h10);
        check("stall_head_instr", bus.OutInstruction, 32'hB000_0010);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("stall_next_pc", bus.OutPC, 32'h14);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("stall_drained", {31'b0, bus.OutValid}, 32'h0);

        // Flush with count = 2 and a pending push
        step(1'b1, 32'h40, 32'hC000_0040, 1'b0, 1'b0);
        step(1'b1, 32'h44, 32'hC000_0044, 1'b0, 1'b0);
        step(1'b1, 32'h48, 32'hC000_0048, 1'b1, 1'b1);
        check("flush_valid", {31'b0, bus.OutValid}, 32'h0);
        check("flush_ready", {31'b0, bus.InReady}, 32'h1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("flush_dropped", {31'b0, bus.OutValid}, 32'h0);

`ifdef IFID_STALL_CNT_EN
        // Stall counter: five stalled cycles, then flush must not clear it
        begin
            logic [31:0] s0;
            step(1'b1, 32'h60, 32'hD000_0060, 1'b0, 1'b0);
            s0 = StallCount;
            repeat (5) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            check("stall_cnt_5", StallCount, s0 + 32'd5);
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
            check("stall_cnt_flush", StallCount, s0 + 32'd5);
        end
`endif

        // PC wrap, then asynchronous reset mid-cycle with two entries held
        step(1'b1, 32'hFFFF_FFFC, 32'hE000_0001, 1'b0, 1'b0);
        check("wrap_pc4", bus.OutPCPlus4, 32'h0);
        step(1'b1, 32'h20, 32'hE000_0020, 1'b0, 1'b0);
        check("pre_rst_ready", {31'b0, bus.InReady}, 32'h0);
        #2;
        Reset = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, bus.OutValid}, 32'h0);
        check("async_rst_ready", {31'b0, bus.InReady}, 32'h1);
        check("async_rst_instr", bus.OutInstruction, NOP_EXP);
`ifdef IFID_STALL_CNT_EN
        check("async_rst_stall", StallCount, 32'h0);
        exp_stall = 0;
`endif
        exp_q.delete();
        Reset = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom();
            step($urandom_range(0, 9) < 7, pc, $urandom(),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end

        // Drain and confirm every accepted entry was presented
        repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drain_left", exp_q.size(), 32'h0);

        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the instruction and PC width.
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h00000000, the value driven on OutInstruction when the buffer is empty.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port InInstruction, input, DATA_W bits: the instruction word from the fetch unit.
REQ-006 The block SHALL have port InPC, input, DATA_W bits: the PC of InInstruction (fetch PCResult).
REQ-007 The block SHALL have port InValid, input, 1 bit: InInstruction/InPC are valid this cycle.
REQ-008 The block SHALL have port InReady, output, 1 bit: the buffer can accept an entry this cycle.
REQ-009 The block SHALL have port Flush, input, 1 bit: discard all buffered entries (branch/jump redirect).
REQ-010 The block SHALL have ports OutInstruction, OutPC and OutPCPlus4, output, DATA_W bits each: the head entry to decode.
REQ-011 The block SHALL have port OutValid, output, 1 bit: the head entry is valid.
REQ-012 The block SHALL have port OutReady, input, 1 bit: decode consumes the head this cycle (0 = stall).

Function
REQ-013 The block SHALL be a 2-entry in-order FIFO of {instruction, PC} pairs, with a count of 0..2.
REQ-014 The block SHALL perform a push when InValid && InReady, and a pop when OutValid && OutReady.
REQ-015 The block SHALL derive InReady from registered state only: InReady = (count < 2).
REQ-016 The block SHALL drive OutValid = (count > 0); it SHALL drive OutInstruction/OutPC from the head entry, and NOP_WORD/0 when count = 0.
REQ-017 The block SHALL have a latency of 1 cycle: an entry pushed at edge N SHALL be visible on the outputs after edge N when the buffer was empty.
REQ-018 On a simultaneous push and pop with count = 1, the block SHALL present the new entry as head after the edge and keep count at 1.
REQ-019 On a simultaneous push and pop with count = 2, no push SHALL occur (InReady = 0); the pop SHALL leave count at 1.
REQ-020 When OutReady = 0, the block SHALL hold the head entry and its outputs stable until popped.
REQ-021 The block SHALL drive OutPCPlus4 = OutPC + 4 modulo 2^DATA_W (for example 0xFFFFFFFC SHALL wrap to 0x00000000); it SHALL drive 4 when the buffer is empty.
REQ-022 Flush SHALL set count to 0 at the next edge; Flush SHALL dominate a push or pop in the same cycle, and that cycle's input SHALL be dropped.
REQ-023 The block SHALL preserve order: entries SHALL leave in the order they were accepted.

Reset
REQ-024 When Reset = 0, the block SHALL immediately clear count, the pointers and both entries, regardless of Clk.
REQ-025 During reset, the outputs SHALL be: OutValid = 0, InReady = 1, OutInstruction = NOP_WORD, OutPC = 0, OutPCPlus4 = 4, StallCount = 0.
REQ-026 If Reset is asserted mid-operation, the block SHALL discard buffered entries without emitting them.

Configuration
REQ-027 When IFID_STALL_CNT_EN is defined, the block SHALL add output StallCount (32 bits), incremented each cycle OutValid && !OutReady, wrapping at 2^32 and cleared by Reset but not by Flush.
REQ-028 When IFID_STALL_CNT_EN is undefined, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package if_id_pkg SHALL hold the NOP constant, the depth constant (2) and the entry typedef {instruction, pc}.
REQ-030 The block SHALL contain no sub-module; storage, pointers and the count SHALL be implemented inline.

Verification
REQ-031 Reset scenario: hold Reset = 0 for 2 cycles, then release -> OutValid = 0, InReady = 1, OutInstruction = 0, OutPCPlus4 = 4.
REQ-032 Streaming scenario: push PC 0, 4, 8 on consecutive cycles with OutReady = 1 -> each appears 1 cycle later, in order, with OutPCPlus4 = 4, 8, 12.
REQ-033 Stall scenario: OutReady = 0 while pushing PC 0x10, 0x14, 0x18 -> InReady = 0 after two pushes, PC 0x18 is not accepted, and the head stays at 0x10; releasing OutReady then yields 0x10 and 0x14.
REQ-034 Flush scenario: assert Flush with count = 2 and InValid = 1 -> next cycle OutValid = 0, count = 0, and the input is dropped.
REQ-035 Wrap and reset scenario: push PC 0xFFFFFFFC -> OutPCPlus4 = 0; with count = 2, pulse Reset low mid-cycle -> OutValid = 0 immediately.
REQ-036 Stall-counter scenario (IFID_STALL_CNT_EN defined): stall for 5 cycles with OutValid = 1 -> StallCount = 5; a following Flush leaves StallCount = 5.
